// File: rtl/mesh_router_cfg_seq_pkg.sv
// Shared types and helpers for the NoC router configuration sequencer.
package mesh_router_cfg_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StEndp,
    StFin
  } cfg_state_e;

  // Counter widths never drop below one bit, even for degenerate dimensions.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mesh_router_cfg_seq_if.sv
// Valid/ready config bus carrying one header or endpoint word per transfer.
interface mesh_router_cfg_seq_if #(
  parameter int unsigned NRw = 4,
  parameter int unsigned RAw = 4,
  parameter int unsigned NLw = 1,
  parameter int unsigned EAw = 5,
  parameter int unsigned NEw = 4
) ();
  logic           valid;
  logic           ready;
  logic           is_hdr;
  logic [NRw-1:0] router_id;
  logic [RAw-1:0] router_addr;
  logic [NLw-1:0] endp_idx;
  logic [EAw-1:0] endp_addr;
  logic [NEw-1:0] endp_id;

  modport master (
    output valid, is_hdr, router_id, router_addr, endp_idx, endp_addr, endp_id,
    input  ready
  );

  modport slave (
    input  valid, is_hdr, router_id, router_addr, endp_idx, endp_addr, endp_id,
    output ready
  );
endinterface

// File: rtl/mesh_router_cfg_seq_walker.sv
// Row-major x/y/l walker over the mesh; one step per accepted endpoint word.
module mesh_router_cfg_seq_walker #(
  parameter int unsigned NX  = 4,
  parameter int unsigned NY  = 4,
  parameter int unsigned NL  = 1,
  parameter int unsigned NXw = 2,
  parameter int unsigned NYw = 2,
  parameter int unsigned NLw = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr_i,
  input  logic           adv_i,
  output logic [NXw-1:0] x_o,
  output logic [NYw-1:0] y_o,
  output logic [NLw-1:0] l_o,
  output logic           last_l_o,
  output logic           last_rtr_o
);
  logic [NXw-1:0] x_q, x_d;
  logic [NYw-1:0] y_q, y_d;
  logic [NLw-1:0] l_q, l_d;
  logic           last_x, last_y;

  assign last_l_o   = (l_q == NLw'(NL - 1));
  assign last_x     = (x_q == NXw'(NX - 1));
  assign last_y     = (y_q == NYw'(NY - 1));
  assign last_rtr_o = last_x & last_y;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    l_d = l_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
      l_d = '0;
    end else if (adv_i) begin
      if (!last_l_o) begin
        l_d = l_q + NLw'(1);
      end else begin
        l_d = '0;
        if (last_x) begin
          x_d = '0;
          y_d = last_y ? '0 : y_q + NYw'(1);
        end else begin
          x_d = x_q + NXw'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
      l_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      l_q <= l_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;
  assign l_o = l_q;
endmodule

// File: rtl/mesh_router_cfg_seq.sv
// Post-reset sequencer streaming header + endpoint config words for every router.
module mesh_router_cfg_seq
  import mesh_router_cfg_seq_pkg::*;
#(
  parameter int unsigned NX  = 4,
  parameter int unsigned NY  = 4,
  parameter int unsigned NL  = 1,
  parameter int unsigned NXw = clog2_min1(NX),
  parameter int unsigned NYw = clog2_min1(NY),
  parameter int unsigned NLw = clog2_min1(NL)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  mesh_router_cfg_seq_if.master        cfg
);
  localparam int unsigned RAw = NXw + NYw;
  localparam int unsigned NRw = clog2_min1(NX * NY);
  localparam int unsigned NEw = clog2_min1(NX * NY * NL);

  cfg_state_e     state_q, state_d;
  logic [NRw-1:0] rid_q, rid_d;
  logic [NEw-1:0] eid_q, eid_d;
  logic           clr, adv, valid, is_hdr;
  logic [NXw-1:0] x;
  logic [NYw-1:0] y;
  logic [NLw-1:0] l;
  logic           last_l, last_rtr;

  mesh_router_cfg_seq_walker #(
    .NX (NX),
    .NY (NY),
    .NL (NL),
    .NXw(NXw),
    .NYw(NYw),
    .NLw(NLw)
  ) u_walker (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (clr),
    .adv_i     (adv),
    .x_o       (x),
    .y_o       (y),
    .l_o       (l),
    .last_l_o  (last_l),
    .last_rtr_o(last_rtr)
  );

  // Running ids replace y*NX+x and id*NL+l multiplies.
  always_comb begin
    state_d = state_q;
    rid_d   = rid_q;
    eid_d   = eid_q;
    clr     = 1'b0;
    adv     = 1'b0;
    valid   = 1'b0;
    is_hdr  = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StHdr;
          clr     = 1'b1;
          rid_d   = '0;
          eid_d   = '0;
        end
      end
      StHdr: begin
        valid  = 1'b1;
        is_hdr = 1'b1;
        busy_o = 1'b1;
        if (cfg.ready) state_d = StEndp;
      end
      StEndp: begin
        valid  = 1'b1;
        busy_o = 1'b1;
        if (cfg.ready) begin
          adv   = 1'b1;
          eid_d = eid_q + NEw'(1);
          if (last_l) begin
            rid_d   = rid_q + NRw'(1);
            state_d = last_rtr ? StFin : StHdr;
          end
        end
      end
      StFin: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rid_q   <= '0;
      eid_q   <= '0;
    end else begin
      state_q <= state_d;
      rid_q   <= rid_d;
      eid_q   <= eid_d;
    end
  end

  // Payload is forced to zero whenever no word is offered; endpoint fields zero on headers.
  assign cfg.valid       = valid;
  assign cfg.is_hdr      = is_hdr;
  assign cfg.router_id   = valid ? rid_q : '0;
  assign cfg.router_addr = valid ? {y, x} : '0;
  assign cfg.endp_idx    = (valid && !is_hdr) ? l : '0;
  assign cfg.endp_addr   = (valid && !is_hdr) ? {l, y, x} : '0;
  assign cfg.endp_id     = (valid && !is_hdr) ? eid_q : '0;
endmodule
